// File: rtl/vib_capture_ctrl.sv
// rtl/vib_capture_ctrl.sv - trigger-based ring capture sequencer driving a dual-port sample RAM
module vib_capture_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int POST_TRIG  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PRE_MAX   = ADDR_WIDTH'(DEPTH - 1 - POST_TRIG);
  localparam logic [ADDR_WIDTH-1:0] POST_LAST = ADDR_WIDTH'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_FETCH,
    S_READ
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] wp, rp, pre_cnt, post_cnt, rd_cnt;
  logic                  trig_r;
  logic                  wr_fire, trig_fire, rd_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_r_addr = '0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    done       = 1'b0;
    wr_fire    = 1'b0;
    trig_fire  = 1'b0;
    rd_hs      = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) state_next = S_ARMED;
      end
      S_ARMED: begin
        wr_fire = sample_valid;
        // Trigger only once the pre-window already holds its full share of samples
        if (sample_valid && pre_cnt == PRE_MAX && sample >= threshold) begin
          trig_fire  = 1'b1;
          state_next = (POST_TRIG == 0) ? S_FETCH : S_POST;
        end
      end
      S_POST: begin
        wr_fire = sample_valid;
        if (sample_valid && post_cnt == POST_LAST) state_next = S_FETCH;
      end
      S_FETCH: begin
        ram_en     = 1'b1;
        ram_r_addr = wp;
        state_next = S_READ;
      end
      S_READ: begin
        rd_valid   = 1'b1;
        rd_last    = (rd_cnt == LAST_IDX);
        ram_en     = rd_ready && !rd_last;
        ram_r_addr = rp;
        rd_hs      = rd_ready;
        if (rd_ready && rd_last) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
      wr_fire    = 1'b0;
      trig_fire  = 1'b0;
      rd_hs      = 1'b0;
    end
    if (wr_fire) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      trig_r   <= 1'b0;
    end else begin
      if (state == S_IDLE && arm && !abort) begin
        wp      <= '0;
        pre_cnt <= '0;
      end
      if (wr_fire) begin
        wp <= wp + 1'b1;
        if (state == S_ARMED && pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
        if (state == S_POST) post_cnt <= post_cnt + 1'b1;
      end
      if (trig_fire) begin
        trig_r   <= 1'b1;
        post_cnt <= '0;
      end
      // wp now points at the oldest sample; its read is issued this cycle
      if (state == S_FETCH && !abort) begin
        rp     <= wp + 1'b1;
        rd_cnt <= '0;
      end
      if (rd_hs) begin
        rp     <= rp + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (state_next == S_IDLE) trig_r <= 1'b0;
    end
  end

  assign ram_w_addr = wp;
  assign ram_di     = sample;
  assign rd_data    = ram_dout;
  assign busy       = (state != S_IDLE);
  assign triggered  = trig_r;

endmodule

// File: doc/vib_capture_ctrl.md
Name: vib_capture_ctrl

Overview:
Trigger-based capture sequencer that sits directly upstream of the dual-port sample RAM. It drives the RAM write and read ports. While armed, it writes a continuous ring of accelerometer samples into the RAM. When a sample reaches the threshold it captures a fixed number of post-trigger samples, then streams the whole window out oldest-first over a valid/ready interface.

Parameters:
DATA_WIDTH, 8, sample width; must match the RAM data width.
ADDR_WIDTH, 4, RAM address width; DEPTH = 2^ADDR_WIDTH.
POST_TRIG, 8, samples captured after the trigger sample; legal range 0 to DEPTH-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous reset, active-high.
arm  in  1  single-cycle start request; honoured only in IDLE.
abort  in  1  returns to IDLE from any state next cycle; has no RAM side effects.
sample_valid  in  1  qualifies sample.
sample  in  DATA_WIDTH  unsigned sample.
threshold  in  DATA_WIDTH  unsigned trigger level; sampled every cycle.
ram_en  out  1  RAM enable (combinational).
ram_we  out  1  RAM write enable (combinational).
ram_w_addr  out  ADDR_WIDTH  write address, equal to wp.
ram_di  out  DATA_WIDTH  write data, equal to sample (combinational).
ram_r_addr  out  ADDR_WIDTH  read address (combinational).
ram_dout  in  DATA_WIDTH  registered RAM read data; 1-cycle latency when ram_en=1, held when ram_en=0.
rd_valid  out  1  readout data valid.
rd_ready  in  1  readout consumer ready.
rd_data  out  DATA_WIDTH  equal to ram_dout.
rd_last  out  1  high with the final (DEPTH-th) readout word.
busy  out  1  high whenever state is not IDLE.
triggered  out  1  set on trigger acceptance; cleared on return to IDLE.
done  out  1  single-cycle pulse on the final readout handshake.

Behaviour:
- Reset (asynchronous): state=IDLE, wp=0, rp=0, pre_cnt=0, post_cnt=0, triggered=0. All outputs are 0 during reset: ram_en, ram_we, rd_valid, rd_last, busy, done; addresses 0.
- States: IDLE, ARMED, POST, FETCH, READ.
- IDLE:
  - All RAM controls are 0.
  - arm=1 -> ARMED; wp=0, pre_cnt=0.
- ARMED:
  - On each sample_valid: ram_en=1, ram_we=1, ram_w_addr=wp, ram_di=sample; wp++ (wraps modulo DEPTH).
  - pre_cnt increments and saturates at DEPTH-1-POST_TRIG.
  - Trigger condition: sample_valid AND sample>=threshold AND pre_cnt==DEPTH-1-POST_TRIG (pre-window full before this sample).
  - The triggering sample is written.
  - On trigger: triggered=1 next cycle; post_cnt=0. Next state is POST, or FETCH if POST_TRIG=0.
  - A sample >= threshold before the pre-window is full is written but does not trigger.
- POST:
  - Each sample_valid is written as in ARMED and post_cnt++.
  - On the sample_valid that makes post_cnt==POST_TRIG, that sample is written and the next state is FETCH.
  - Threshold is ignored in POST.
- FETCH (1 cycle):
  - ram_en=1, ram_we=0, ram_r_addr=wp (the oldest sample).
  - rp=wp+1, rd_cnt=0; next state READ.
- READ:
  - rd_valid=1.
  - rd_last=1 when rd_cnt==DEPTH-1.
  - ram_en = rd_ready AND NOT rd_last; ram_r_addr=rp.
  - On handshake (rd_valid AND rd_ready): rp++ and rd_cnt++. If rd_last, then done=1 for that cycle and the next state is IDLE.
  - While rd_ready=0, ram_en=0, so rd_data holds stable. No words are dropped or duplicated.
  - Throughput: 1 word/cycle under continuous ready.
- Readout order: DEPTH-1-POST_TRIG pre-trigger samples, then the trigger sample at index DEPTH-1-POST_TRIG, then POST_TRIG post samples.
- sample_valid is ignored in IDLE, FETCH and READ.
- arm is ignored when not in IDLE.
- abort has priority over all other transitions. Next state is IDLE and triggered clears; RAM contents are left untouched.
- Reset mid-operation: immediate return to reset values; the next arm restarts capture at wp=0.

Test Plan:
1. DEPTH=16, POST_TRIG=8, threshold=100:
   - Stimulus: arm; feed 20 valid samples with values 10..29, then 200, then 30..37; hold rd_ready=1.
   - Required response: triggered rises after 200; 16 readout words, 23..29, 200, 30..37, on consecutive cycles. rd_last and done occur on word 16; busy=0 the next cycle.
2. Early threshold crossing:
   - Stimulus: arm; feed 3 samples, then 200, then 10 samples below threshold, then 150.
   - Required response: no trigger at 200 (pre_cnt=3). Trigger occurs at 150. The window ends with 150 followed by 8 post samples.
3. Backpressure:
   - Stimulus: run scenario 1 with rd_ready toggling on a pseudo-random pattern.
   - Required response: rd_data is stable while rd_valid=1 and rd_ready=0; the same 16-word sequence is delivered exactly once.
4. sample_valid gaps and wrap:
   - Stimulus: valid every third cycle, 40 pre-trigger samples, so wp wraps twice.
   - Required response: only valid samples are written. Readout starts at the oldest sample and ordering is correct across the wrap.
5. Abort and reset:
   - Stimulus: abort during POST; then a new arm; then assert rst during READ.
   - Required response: after abort, busy=0 and triggered=0 next cycle, and the new arm captures normally. After rst, all outputs are 0 immediately; a following arm works with wp=0.
6. POST_TRIG=0 build:
   - Stimulus: trigger after 15 pre-trigger samples.
   - Required response: FETCH immediately after the trigger sample; the trigger sample is the last readout word, with rd_last=1.
